// File: rtl/voice_pkg.sv
// Shared definitions for the voice-module UART link (receiver and transmitter).
package voice_pkg;

    localparam logic [7:0] HDR_BYTE  = 8'h7E;
    localparam logic [7:0] TAIL_BYTE = 8'hEF;

    // Response frame parser states, one per expected byte position.
    typedef enum logic [2:0] {
        W_HDR  = 3'd0,
        W_CMD  = 3'd1,
        W_DHI  = 3'd2,
        W_DLO  = 3'd3,
        W_CHK  = 3'd4,
        W_TAIL = 3'd5
    } frame_state_t;

    // Clock cycles per UART bit.
    function automatic int unsigned bit_cyc(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

    // Frame checksum: 8-bit wrapping sum of the payload bytes.
    function automatic logic [7:0] frame_sum(input logic [7:0] cmd, input logic [7:0] dhi,
                                             input logic [7:0] dlo);
        return cmd + dhi + dlo;
    endfunction

endpackage

// File: rtl/voice_uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser, start-edge detect and bit-level FSM.
// byte_ok / byte_bad are asserted in the stop-bit sample cycle.
module voice_uart_rx_byte
    import voice_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_ok,
    output logic       byte_bad,
    output logic [7:0] byte_data
);

    localparam int unsigned BIT_CYC = bit_cyc(CLK_HZ, BAUD);
    localparam int unsigned HALF    = BIT_CYC / 2;
    localparam int unsigned CNT_W   = $clog2(BIT_CYC + 1);

    localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(HALF - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             stop_sample;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    // NOTE: these preset to 1 (idle line) so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make each flop take the previous stage's old value.
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Bit-level FSM: start validation at mid-bit, then one sample per bit time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !rx_sync) state <= S_START;
                end
                S_START: begin
                    if (cnt == LAST_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == LAST_FULL) begin
                        cnt     <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == LAST_FULL) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign stop_sample = (state == S_STOP) && (cnt == LAST_FULL);
    assign byte_ok     = stop_sample &&  rx_sync;
    assign byte_bad    = stop_sample && !rx_sync;
    assign byte_data   = shift;

endmodule

// File: rtl/voice_resp_rx.sv
// Voice-module response receiver: parses 7E CMD DHI DLO CHK EF frames from the
// voice chip's TX line and strobes each validated response to the control logic.
module voice_resp_rx
    import voice_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned BAUD    = 9600,
    parameter logic [7:0]  HDR     = HDR_BYTE,
    parameter logic [7:0]  TAIL    = TAIL_BYTE,
    parameter int unsigned TO_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        resp_valid,
    output logic [7:0]  resp_cmd,
    output logic [15:0] resp_data,
    output logic        frame_err,
    output logic        busy
);

    localparam int unsigned BIT_CYC = bit_cyc(CLK_HZ, BAUD);
    localparam int unsigned TO_CYC  = TO_BITS * BIT_CYC;
    localparam int unsigned TO_W    = $clog2(TO_CYC + 1);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

    logic            byte_ok;
    logic            byte_bad;
    logic [7:0]      byte_data;

    frame_state_t    state;
    logic [7:0]      cmd_q;
    logic [7:0]      dhi_q;
    logic [7:0]      dlo_q;
    logic [7:0]      chk_q;
    logic [TO_W-1:0] to_cnt;
    logic            sum_ok;

    voice_uart_rx_byte #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_byte (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (uart_rx),
        .byte_ok   (byte_ok),
        .byte_bad  (byte_bad),
        .byte_data (byte_data)
    );

    assign sum_ok = (frame_sum(cmd_q, dhi_q, dlo_q) == chk_q);
    assign busy   = (state != W_HDR);

    // Inter-byte timeout: runs only inside a frame, reloads on every good byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == W_HDR || byte_ok) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Frame FSM: collect payload into shadows, validate on the tail byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: shadow registers are reset as well, so a partial frame never leaks after reset.
            state      <= W_HDR;
            cmd_q      <= '0;
            dhi_q      <= '0;
            dlo_q      <= '0;
            chk_q      <= '0;
            resp_valid <= 1'b0;
            frame_err  <= 1'b0;
            resp_cmd   <= '0;
            resp_data  <= '0;
        end else begin
            resp_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (state == W_HDR) begin
                if (byte_ok && byte_data == HDR) state <= W_CMD;
            end else if (byte_ok) begin
                // A good byte always takes priority over a coincident timeout.
                case (state)
                    W_CMD: begin
                        cmd_q <= byte_data;
                        state <= W_DHI;
                    end
                    W_DHI: begin
                        dhi_q <= byte_data;
                        state <= W_DLO;
                    end
                    W_DLO: begin
                        dlo_q <= byte_data;
                        state <= W_CHK;
                    end
                    W_CHK: begin
                        chk_q <= byte_data;
                        state <= W_TAIL;
                    end
                    W_TAIL: begin
                        if (byte_data == TAIL && sum_ok) begin
                            resp_valid <= 1'b1;
                            resp_cmd   <= cmd_q;
                            resp_data  <= {dhi_q, dlo_q};
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= W_HDR;
                    end
                    default: state <= W_HDR;
                endcase
            end else if (byte_bad || to_cnt == TO_LAST) begin
                frame_err <= 1'b1;
                state     <= W_HDR;
            end
        end
    end

endmodule

// File: tb/tb_voice_resp_rx.sv
// Self-checking bench for voice_resp_rx: table of frames with expected strobes,
// a scoreboard queue popped on every strobe, and hand sequences for glitch and reset.
module tb_voice_resp_rx;

    localparam int unsigned CLK_HZ  = 50_000_000;
    localparam int unsigned BAUD    = 3_125_000;
    localparam int unsigned BIT_CYC = CLK_HZ / BAUD;

    logic        clk;
    logic        rst_n;
    logic        uart_rx;
    logic        resp_valid;
    logic [7:0]  resp_cmd;
    logic [15:0] resp_data;
    logic        frame_err;
    logic        busy;

    voice_resp_rx #(
        .CLK_HZ  (CLK_HZ),
        .BAUD    (BAUD),
        .HDR     (8'h7E),
        .TAIL    (8'hEF),
        .TO_BITS (20)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .resp_valid (resp_valid),
        .resp_cmd   (resp_cmd),
        .resp_data  (resp_data),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_valid;
        logic [7:0]  cmd;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic [47:0] bytes;
        int          n;
        int          bad_idx;
        int          gap_bits;
        bit          has_exp;
        exp_t        exp;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic vec_t mk(input logic [47:0] bytes, input int n, input int bad_idx,
                                input int gap_bits, input bit has_exp, input bit is_valid,
                                input logic [7:0] cmd, input logic [15:0] data);
        vec_t v;
        v.bytes    = bytes;
        v.n        = n;
        v.bad_idx  = bad_idx;
        v.gap_bits = gap_bits;
        v.has_exp  = has_exp;
        v.exp      = '{is_valid: is_valid, cmd: cmd, data: data};
        return v;
    endfunction

    task automatic bits(input int n);
        repeat (n * BIT_CYC) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        uart_rx = 1'b0;
        bits(1);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            bits(1);
        end
        uart_rx = stop_ok;
        bits(1);
        uart_rx = 1'b1;
        bits(2);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 8 * BIT_CYC && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check({name, "_drain"}, sb.size(), 0);
        check({name, "_busy"}, busy, 0);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        logic [47:0] bb;
        if (v.has_exp) sb.push_back(v.exp);
        bb = v.bytes;
        for (int i = 0; i < v.n; i++) send_byte(bb[47 - 8*i -: 8], i != v.bad_idx);
        bits(v.gap_bits);
        drain(name);
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected outcome.
    always @(negedge clk) begin
        if (rst_n && (resp_valid || frame_err)) begin
            exp_t e;
            check("exclusive", {31'd0, resp_valid & frame_err}, 0);
            if (sb.size() == 0) begin
                check("spurious_strobe", {30'd0, resp_valid, frame_err}, 0);
            end else begin
                e = sb.pop_front();
                check("strobe_kind", {30'd0, resp_valid, frame_err}, {30'd0, e.is_valid, !e.is_valid});
                check("resp_cmd", resp_cmd, e.cmd);
                check("resp_data", resp_data, e.data);
            end
        end
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(48'h7E_01_00_05_06_EF, 6, -1, 0, 1, 1, 8'h01, 16'h0005);
        vecs[1] = mk(48'h7E_01_00_05_07_EF, 6, -1, 0, 1, 0, 8'h01, 16'h0005);
        vecs[2] = mk(48'h7E_FF_80_82_01_EF, 6, -1, 0, 1, 1, 8'hFF, 16'h8082);
        vecs[3] = mk(48'h55_AA_00_00_00_00, 2, -1, 0, 0, 0, 8'h00, 16'h0000);
        vecs[4] = mk(48'h7E_02_12_34_48_EF, 6, -1, 0, 1, 1, 8'h02, 16'h1234);
        vecs[5] = mk(48'h7E_03_00_01_04_EF, 6,  2, 0, 1, 0, 8'h02, 16'h1234);
        vecs[6] = mk(48'h7E_03_00_00_00_00, 2, -1, 25, 1, 0, 8'h02, 16'h1234);
        vecs[7] = mk(48'h7E_05_00_10_15_EF, 6, -1, 0, 1, 1, 8'h05, 16'h0010);
        vecs[8] = mk(48'h7E_05_00_10_15_EE, 6, -1, 0, 1, 0, 8'h05, 16'h0010);

        uart_rx = 1'b1;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", resp_valid, 0);
        check("rst_err", frame_err, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd", resp_cmd, 0);
        check("rst_data", resp_data, 0);
        rst_n = 1'b1;
        bits(2);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Short low glitch on an idle line must be rejected as a false start.
        @(posedge clk);
        uart_rx = 1'b0;
        repeat (BIT_CYC * 3 / 10) @(posedge clk);
        uart_rx = 1'b1;
        bits(3);
        @(negedge clk);
        check("glitch_busy", busy, 0);
        check("glitch_drain", sb.size(), 0);
        run_vec(mk(48'h7E_06_00_01_07_EF, 6, -1, 0, 1, 1, 8'h06, 16'h0001), "post_glitch");

        // Reset in the middle of the DHI byte discards the partial frame.
        send_byte(8'h7E, 1'b1);
        send_byte(8'h01, 1'b1);
        @(negedge clk);
        check("mid_busy", busy, 1);
        uart_rx = 1'b0;
        bits(3);
        rst_n = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_cmd", resp_cmd, 0);
        check("mid_rst_data", resp_data, 0);
        check("mid_rst_busy", busy, 0);
        rst_n = 1'b1;
        bits(25);
        check("post_rst_drain", sb.size(), 0);
        run_vec(mk(48'h7E_04_AB_CD_7C_EF, 6, -1, 0, 1, 1, 8'h04, 16'hABCD), "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
